fb_mem_arbiter: RTL and testbench

FB_MEM_ARBITER -- requirements
Module: fb_mem_arbiter

---
 rtl/fb_pkg.sv | 22 ++
 rtl/fb_rd_tracker.sv | 45 ++++
 rtl/fb_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_fb_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer memory arbiter: default widths,
// client identifiers and the starvation-counter sizing helper.
package fb_pkg;

  localparam int ADDR_W_DEF = 17;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    CLIENT_C0 = 1'b0,
    CLIENT_C1 = 1'b1
  } client_e;

  // Bits needed to hold 0..starve_max inclusive.
  function automatic int starve_cnt_w(input int starve_max);
    if (starve_max < 1) begin
      return 1;
    end else begin
      return $clog2(starve_max + 1);
    end
  endfunction

endpackage

// File: rtl/fb_rd_tracker.sv
// Read-return tracker: RD_LAT-deep valid/owner shift register fed from the
// memory command cycle, so rvalid lines up with mem_readdata in issue order.
module fb_rd_tracker
  import fb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_valid,
  input  client_e push_owner,
  output logic    rvalid_c0,
  output logic    rvalid_c1
);

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT-1:0] own_q, own_d;

  // Shift one stage per cycle; stage 0 captures the read in its command cycle.
  always_comb begin
    vld_d    = vld_q;
    own_d    = own_q;
    vld_d[0] = push_valid;
    own_d[0] = push_owner;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      own_d[i] = own_q[i-1];
    end
  end

  // Pipeline state; reset discards every read still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q <= vld_d;
      own_q <= own_d;
    end
  end

  assign rvalid_c0 = vld_q[RD_LAT-1] & (own_q[RD_LAT-1] == 1'(CLIENT_C0));
  assign rvalid_c1 = vld_q[RD_LAT-1] & (own_q[RD_LAT-1] == 1'(CLIENT_C1));

endmodule

// File: rtl/fb_mem_arbiter.sv
// Two-client arbiter in front of a single-port frame-buffer memory: scanout
// (client 0) has priority, client 1 is forced through after STARVE_MAX losses.
module fb_mem_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                c0_req,
  input  logic [ADDR_W-1:0]   c0_addr,
  output logic                c0_gnt,
  output logic                c0_rvalid,
  output logic [DATA_W-1:0]   c0_rdata,
  input  logic                c1_req,
  input  logic                c1_we,
  input  logic [ADDR_W-1:0]   c1_addr,
  input  logic [DATA_W-1:0]   c1_wdata,
  input  logic [DATA_W/8-1:0] c1_be,
  output logic                c1_gnt,
  output logic                c1_rvalid,
  output logic [DATA_W-1:0]   c1_rdata,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_clken,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int CNT_W = starve_cnt_w(STARVE_MAX);
  localparam int BE_W  = DATA_W / 8;

  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              cs_q, cs_d;
  logic              we_q, we_d;
  logic              clken_q, clken_d;
  client_e           owner_q, owner_d;

  logic starve_hit_s;
  logic c1_win_s;
  logic c0_acc_s;
  logic c1_acc_s;
  logic c1_null_s;

  // Arbitration: gnt is combinational so a request can be accepted every cycle.
  always_comb begin
    starve_hit_s = (starve_q == CNT_W'(STARVE_MAX));
    c1_win_s     = c1_req & (~c0_req | starve_hit_s);
    c0_gnt       = ~reset_reset & c0_req & ~c1_win_s;
    c1_gnt       = ~reset_reset & c1_win_s;
    c0_acc_s     = c0_req & c0_gnt;
    c1_acc_s     = c1_req & c1_gnt;
    c1_null_s    = c1_we & (c1_be == {BE_W{1'b0}});
  end

  // Starvation counter only counts losses while client 1 is actually waiting.
  always_comb begin
    starve_d = starve_q;
    if (~c1_req || c1_acc_s) begin
      starve_d = {CNT_W{1'b0}};
    end else if (c0_acc_s && !starve_hit_s) begin
      starve_d = starve_q + CNT_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Next memory command; a zero-byte-enable write is swallowed like an idle cycle.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    owner_d = owner_q;
    cs_d    = 1'b0;
    we_d    = 1'b0;
    clken_d = 1'b1;
    if (c0_acc_s) begin
      addr_d  = c0_addr;
      be_d    = {BE_W{1'b1}};
      cs_d    = 1'b1;
      owner_d = CLIENT_C0;
    end else if (c1_acc_s && !c1_null_s) begin
      addr_d  = c1_addr;
      wdata_d = c1_wdata;
      be_d    = c1_be;
      cs_d    = 1'b1;
      we_d    = c1_we;
      owner_d = CLIENT_C1;
    end else begin
      cs_d = 1'b0;
      we_d = 1'b0;
    end
  end

  // Arbiter and memory-command registers.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      starve_q <= {CNT_W{1'b0}};
      addr_q   <= {ADDR_W{1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
      be_q     <= {BE_W{1'b0}};
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      clken_q  <= 1'b0;
      owner_q  <= CLIENT_C0;
    end else begin
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      cs_q     <= cs_d;
      we_q     <= we_d;
      clken_q  <= clken_d;
      owner_q  <= owner_d;
    end
  end

  assign mem_address    = addr_q;
  assign mem_writedata  = wdata_q;
  assign mem_byteenable = be_q;
  assign mem_chipselect = cs_q;
  assign mem_write      = we_q;
  assign mem_clken      = clken_q;

  fb_rd_tracker #(
    .RD_LAT (RD_LAT)
  ) u_rd_tracker (
    .clk        (clk_clk),
    .rst        (reset_reset),
    .push_valid (cs_q & ~we_q),
    .push_owner (owner_q),
    .rvalid_c0  (c0_rvalid),
    .rvalid_c1  (c1_rvalid)
  );

  assign c0_rdata = mem_readdata;
  assign c1_rdata = mem_readdata;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed bench: one arbiter with RD_LAT=1 on a byte-enabled memory model,
// and one with RD_LAT=3 on an address-pattern read pipeline.
module tb_fb_mem_arbiter;

  logic clk;
  logic rst;

  logic        c0_req, c0_gnt, c0_rvalid;
  logic [16:0] c0_addr;
  logic [31:0] c0_rdata;
  logic        c1_req, c1_we, c1_gnt, c1_rvalid;
  logic [16:0] c1_addr;
  logic [31:0] c1_wdata, c1_rdata;
  logic [3:0]  c1_be;
  logic [16:0] mem_address;
  logic        mem_chipselect, mem_clken, mem_write;
  logic [31:0] mem_writedata, mem_readdata;
  logic [3:0]  mem_byteenable;

  logic        b_c0_req, b_c0_gnt, b_c0_rvalid;
  logic [16:0] b_c0_addr;
  logic [31:0] b_c0_rdata;
  logic        b_c1_req, b_c1_we, b_c1_gnt, b_c1_rvalid;
  logic [16:0] b_c1_addr;
  logic [31:0] b_c1_wdata, b_c1_rdata;
  logic [3:0]  b_c1_be;
  logic [16:0] b_mem_address;
  logic        b_mem_chipselect, b_mem_clken, b_mem_write;
  logic [31:0] b_mem_writedata, b_mem_readdata;
  logic [3:0]  b_mem_byteenable;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fb_mem_arbiter #(.ADDR_W(17), .DATA_W(32), .RD_LAT(1), .STARVE_MAX(8)) u_dut (
    .clk_clk(clk), .reset_reset(rst),
    .c0_req(c0_req), .c0_addr(c0_addr), .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata), .c1_be(c1_be),
    .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_clken(mem_clken),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_readdata(mem_readdata)
  );

  fb_mem_arbiter #(.ADDR_W(17), .DATA_W(32), .RD_LAT(3), .STARVE_MAX(8)) u_dut3 (
    .clk_clk(clk), .reset_reset(rst),
    .c0_req(b_c0_req), .c0_addr(b_c0_addr), .c0_gnt(b_c0_gnt), .c0_rvalid(b_c0_rvalid), .c0_rdata(b_c0_rdata),
    .c1_req(b_c1_req), .c1_we(b_c1_we), .c1_addr(b_c1_addr), .c1_wdata(b_c1_wdata), .c1_be(b_c1_be),
    .c1_gnt(b_c1_gnt), .c1_rvalid(b_c1_rvalid), .c1_rdata(b_c1_rdata),
    .mem_address(b_mem_address), .mem_chipselect(b_mem_chipselect), .mem_clken(b_mem_clken),
    .mem_write(b_mem_write), .mem_writedata(b_mem_writedata), .mem_byteenable(b_mem_byteenable),
    .mem_readdata(b_mem_readdata)
  );

  // Memory model for RD_LAT=1: byte-enabled writes, one-cycle registered reads.
  logic [31:0] mem [0:131071];
  logic [31:0] rd1;
  always @(posedge clk) begin
    if (rst) begin
      mem[17'h00010] <= 32'h1234_5678;
    end else if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
      end else begin
        rd1 <= mem[mem_address];
      end
    end
  end
  assign mem_readdata = rd1;

  // Read model for RD_LAT=3: word = 0xC0000000 | address, three stages deep.
  logic [31:0] p0, p1, p2;
  always @(posedge clk) begin
    p0 <= (b_mem_chipselect && !b_mem_write) ? (32'hC000_0000 | {15'd0, b_mem_address}) : 32'h0;
    p1 <= p0;
    p2 <= p1;
  end
  assign b_mem_readdata = p2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [16:0] ea;
    int s;
    rst = 1'b1;
    c0_req = 1'b0; c0_addr = 17'h0;
    c1_req = 1'b0; c1_we = 1'b0; c1_addr = 17'h0; c1_wdata = 32'h0; c1_be = 4'h0;
    b_c0_req = 1'b0; b_c0_addr = 17'h0;
    b_c1_req = 1'b0; b_c1_we = 1'b0; b_c1_addr = 17'h0; b_c1_wdata = 32'h0; b_c1_be = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    c0_req = 1'b1; c0_addr = 17'h00010;
    #1;
    chk("rst_c0_gnt", c0_gnt, 1'b0);
    chk("rst_cs", mem_chipselect, 1'b0);
    chk("rst_clken", mem_clken, 1'b0);
    chk("rst_write", mem_write, 1'b0);
    chk("rst_addr", mem_address, 17'h0);
    chk("rst_be", mem_byteenable, 4'h0);
    chk("rst_wdata", mem_writedata, 32'h0);
    chk("rst_rvalid", c0_rvalid, 1'b0);
    c0_req = 1'b0;
    rst = 1'b0;
    step();

    // c0 read of 0x00010
    c0_req = 1'b1; c0_addr = 17'h00010;
    #1;
    chk("rd0_c0_gnt", c0_gnt, 1'b1);
    chk("rd0_c1_gnt", c1_gnt, 1'b0);
    chk("rd0_clken", mem_clken, 1'b1);
    step();
    c0_req = 1'b0;
    #1;
    chk("rd0_cmd_cs", mem_chipselect, 1'b1);
    chk("rd0_cmd_addr", mem_address, 17'h00010);
    chk("rd0_cmd_we", mem_write, 1'b0);
    chk("rd0_cmd_be", mem_byteenable, 4'hF);
    step();
    chk("rd0_rvalid", c0_rvalid, 1'b1);
    chk("rd0_rdata", c0_rdata, 32'h1234_5678);
    chk("rd0_idle_cs", mem_chipselect, 1'b0);
    step();
    chk("rd0_rvalid_once", c0_rvalid, 1'b0);

    // c1 write / read / partial write / read, back to back
    c1_req = 1'b1; c1_we = 1'b1; c1_addr = 17'h1FFFF; c1_wdata = 32'hDEAD_BEEF; c1_be = 4'hF;
    #1;
    chk("w1_gnt", c1_gnt, 1'b1);
    step();
    c1_we = 1'b0;
    #1;
    chk("w1_cs", mem_chipselect, 1'b1);
    chk("w1_we", mem_write, 1'b1);
    chk("w1_wdata", mem_writedata, 32'hDEAD_BEEF);
    chk("w1_addr", mem_address, 17'h1FFFF);
    chk("r1_gnt", c1_gnt, 1'b1);
    step();
    c1_we = 1'b1; c1_wdata = 32'h1111_2222; c1_be = 4'h3;
    #1;
    chk("r1_cs", mem_chipselect, 1'b1);
    chk("r1_we", mem_write, 1'b0);
    chk("w1_no_rvalid", c1_rvalid, 1'b0);
    step();
    c1_we = 1'b0; c1_be = 4'hF;
    #1;
    chk("r1_rvalid", c1_rvalid, 1'b1);
    chk("r1_rdata", c1_rdata, 32'hDEAD_BEEF);
    chk("w2_we", mem_write, 1'b1);
    chk("w2_be", mem_byteenable, 4'h3);
    step();
    c1_req = 1'b0;
    #1;
    chk("w2_no_rvalid", c1_rvalid, 1'b0);
    chk("r2_cs", mem_chipselect, 1'b1);
    step();
    chk("r2_rvalid", c1_rvalid, 1'b1);
    chk("r2_rdata", c1_rdata, 32'hDEAD_2222);
    chk("r2_c0_rvalid", c0_rvalid, 1'b0);
    chk("idle_addr_hold", mem_address, 17'h1FFFF);
    chk("idle_we", mem_write, 1'b0);

    // zero byte-enable write is accepted but never reaches memory
    c1_req = 1'b1; c1_we = 1'b1; c1_addr = 17'h00010; c1_wdata = 32'hFFFF_FFFF; c1_be = 4'h0;
    #1;
    chk("nullw_gnt", c1_gnt, 1'b1);
    step();
    c1_we = 1'b0; c1_be = 4'hF;
    #1;
    chk("nullw_cs", mem_chipselect, 1'b0);
    chk("nullw_we", mem_write, 1'b0);
    step();
    c1_req = 1'b0;
    #1;
    chk("nullr_cs", mem_chipselect, 1'b1);
    step();
    chk("nullr_rvalid", c1_rvalid, 1'b1);
    chk("nullr_rdata", c1_rdata, 32'h1234_5678);

    // starvation: both request continuously
    c0_req = 1'b1; c0_addr = 17'h00010;
    c1_req = 1'b1; c1_we = 1'b0; c1_addr = 17'h1FFFF; c1_be = 4'hF;
    #1;
    for (int i = 0; i < 22; i++) begin
      chk("starve_c0_gnt", c0_gnt, (i % 9) != 8);
      chk("starve_c1_gnt", c1_gnt, (i % 9) == 8);
      chk("starve_onehot", c0_gnt & c1_gnt, 1'b0);
      step();
    end
    c1_req = 1'b0;
    #1;
    chk("c1_low_c0_gnt", c0_gnt, 1'b1);
    step();
    c1_req = 1'b1;
    #1;
    for (int j = 0; j < 9; j++) begin
      chk("clear_c0_gnt", c0_gnt, j != 8);
      chk("clear_c1_gnt", c1_gnt, j == 8);
      step();
    end
    c0_req = 1'b0; c1_req = 1'b0;
    step();
    chk("post_starve_cs", mem_chipselect, 1'b0);
    chk("post_starve_addr", mem_address, 17'h1FFFF);
    chk("post_starve_be", mem_byteenable, 4'hF);
    chk("post_starve_c1_rvalid", c1_rvalid, 1'b1);
    chk("post_starve_c1_rdata", c1_rdata, 32'hDEAD_2222);
    chk("post_starve_c0_rvalid", c0_rvalid, 1'b0);
    step();

    // reset in the middle of three back-to-back reads
    for (int k = 1; k <= 3; k++) begin
      c0_req = 1'b1; c0_addr = 17'(k);
      #1;
      chk("b2b_gnt", c0_gnt, 1'b1);
      step();
    end
    c0_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_cs", mem_chipselect, 1'b0);
    chk("mid_rst_clken", mem_clken, 1'b0);
    chk("mid_rst_addr", mem_address, 17'h0);
    chk("mid_rst_be", mem_byteenable, 4'h0);
    for (int k = 0; k < 8; k++) begin
      if (k == 2) rst = 1'b0;
      chk("mid_rst_c0_rvalid", c0_rvalid, 1'b0);
      chk("mid_rst_c1_rvalid", c1_rvalid, 1'b0);
      step();
    end

    // RD_LAT=3 instance: alternating c0/c1 reads
    for (int t = 0; t < 13; t++) begin
      b_c0_req = 1'b0; b_c1_req = 1'b0; b_c1_we = 1'b0; b_c1_be = 4'hF;
      if (t < 6) begin
        if ((t % 2) == 0) begin
          b_c0_req = 1'b1; b_c0_addr = 17'h100 + 17'(t);
        end else begin
          b_c1_req = 1'b1; b_c1_addr = 17'h200 + 17'(t);
        end
      end
      #1;
      if (t < 6) chk("lat3_gnt", (t % 2 == 0) ? b_c0_gnt : b_c1_gnt, 1'b1);
      s = t - 4;
      chk("lat3_c0_rvalid", b_c0_rvalid, (s >= 0) && (s < 6) && ((s % 2) == 0));
      chk("lat3_c1_rvalid", b_c1_rvalid, (s >= 0) && (s < 6) && ((s % 2) == 1));
      if ((s >= 0) && (s < 6)) begin
        ea = ((s % 2) == 0) ? (17'h100 + 17'(s)) : (17'h200 + 17'(s));
        chk("lat3_rdata", ((s % 2) == 0) ? b_c0_rdata : b_c1_rdata, 32'hC000_0000 | {15'd0, ea});
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
